dequantization: RTL

- Streaming inverse of the accumulator-to-activation quantizer.
- Takes signed DATA_WIDTH activation codes from the encoder output / feature-map buffer and expands them to signed BIAS_WIDTH fixed-point values for the decoder's accumulate path.
- Per code: subtract zero point, multiply by a per-channel scale, left-shift into the accumulator fraction position.
- 2-stage valid/ready pipeline; per-channel scale table loaded through a config port.

---
 rtl/dequantization.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dequantization.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dequantization
//
// Streaming inverse of the accumulator-to-activation quantizer. Each signed
// DW-bit activation code has the zero point removed, is multiplied by the
// per-channel unsigned scale and is shifted left into the accumulator fraction
// position, giving a signed BW-bit value for the decoder accumulate path.
//
// Pipeline: two register stages with valid/ready flow control.
//   stage 1 : d1 = in_data - cfg_zp (exact), scale and last captured
//   stage 2 : out_data = resize((d1 * scale) <<< FRAC_SHIFT)
//
// Optional feature (macro DEQUANT_SAT_EN):
//   defined   : result clamped to the signed BW range, sat_flag port added
//   undefined : result wraps to its low BW bits, no sat_flag port
// DATA_WIDTH / BIAS_WIDTH macros, when defined, set the DW / BW defaults.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready          input handshake
//   in_data [DW]               signed activation code
//   in_last                    last beat of a pixel's channel vector
//   out_valid/out_ready        output handshake
//   out_data [BW]              dequantized value
//   out_last                   in_last carried with its beat
//   cfg_we/cfg_addr/cfg_scale  scale table write port
//   cfg_zp [DW]                signed zero point, sampled at acceptance
//   sat_flag                   (DEQUANT_SAT_EN only) beat was clamped
//
// Handshake: a beat moves when valid & ready are both high on a rising edge.
// A producer holding valid without ready keeps its data stable and does not
// drop valid. in_ready depends on out_ready and pipeline occupancy only,
// never on in_valid.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BIAS_WIDTH
`define BIAS_WIDTH 20
`endif

module dequantization #(
   parameter int DW         = `DATA_WIDTH,
   parameter int BW         = `BIAS_WIDTH,
   parameter int SCALE_W    = 8,
   parameter int FRAC_SHIFT = 4,
   parameter int NUM_CH     = 16,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DW-1:0]      in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BW-1:0]      out_data,
   output logic               out_last,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_addr,
   input  logic [SCALE_W-1:0] cfg_scale,
   input  logic [DW-1:0]      cfg_zp
`ifdef DEQUANT_SAT_EN
   ,
   output logic               sat_flag
`endif
);

   // product width of (DW+1)-bit difference times (SCALE_W+1)-bit scale
   localparam int PW = DW + SCALE_W + 2;
   // wide enough to hold the product after any shift of 0..BW-1
   localparam int RW = BW + DW + SCALE_W;

   // ---------------------------------------------------------------------------
   // Flow control
   // ---------------------------------------------------------------------------
   logic s1_adv;
   logic s2_adv;
   logic in_fire;

   logic                   s1_valid_q, s1_valid_d;
   logic signed [DW:0]     d1_q, d1_d;
   logic [SCALE_W-1:0]     sc1_q, sc1_d;
   logic                   last1_q, last1_d;

   logic                   s2_valid_q, s2_valid_d;
   logic [BW-1:0]          out_data_q, out_data_d;
   logic                   out_last_q, out_last_d;

   logic [CH_W-1:0]        ch_cnt_q, ch_cnt_d;
   logic [SCALE_W-1:0]     scale_q [NUM_CH];
   logic [SCALE_W-1:0]     scale_d [NUM_CH];

   logic signed [PW-1:0]   prod;
   logic [BW-1:0]          r_res;

   always_comb begin
      s2_adv  = !s2_valid_q || out_ready;
      s1_adv  = !s1_valid_q || s2_adv;
      in_fire = in_valid && s1_adv;
   end

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

   // ---------------------------------------------------------------------------
   // Arithmetic for stage 2
   // ---------------------------------------------------------------------------
   // The scale is unsigned, so it is zero-extended before the signed multiply.
   always_comb begin
      prod = $signed(PW'(d1_q)) * $signed(PW'({1'b0, sc1_q}));
   end

`ifdef DEQUANT_SAT_EN
   logic signed [RW-1:0] r_wide;
   logic                 r_sat;
   logic                 sat_q, sat_d;

   // The result fits in BW bits only when bits RW-1 .. BW-1 are all copies of
   // the sign; otherwise clamp toward the sign's end of the range.
   always_comb begin
      r_wide = RW'(prod) <<< FRAC_SHIFT;
      r_sat  = 1'b0;
      r_res  = r_wide[BW-1:0];
      if (!r_wide[RW-1] && (|r_wide[RW-2:BW-1])) begin
         r_sat = 1'b1;
         r_res = {1'b0, {(BW-1){1'b1}}};
      end else if (r_wide[RW-1] && !(&r_wide[RW-2:BW-1])) begin
         r_sat = 1'b1;
         r_res = {1'b1, {(BW-1){1'b0}}};
      end
   end

   assign sat_flag = sat_q;
`else
   // Wrap: keep only the low BW bits of the widened, shifted product.
   always_comb begin
      r_res = BW'(RW'(prod) <<< FRAC_SHIFT);
   end
`endif

   // ---------------------------------------------------------------------------
   // Stage 1: zero-point removal and scale capture
   // ---------------------------------------------------------------------------
   always_comb begin
      s1_valid_d = s1_valid_q;
      d1_d       = d1_q;
      sc1_d      = sc1_q;
      last1_d    = last1_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            // both operands sign-extended by one bit, so the difference is exact
            d1_d    = $signed({in_data[DW-1], in_data}) - $signed({cfg_zp[DW-1], cfg_zp});
            // table read sees the pre-write value when the same entry is written
            sc1_d   = scale_q[ch_cnt_q];
            last1_d = in_last;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: multiply, shift, resize
   // ---------------------------------------------------------------------------
   always_comb begin
      s2_valid_d = s2_valid_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
`ifdef DEQUANT_SAT_EN
      sat_d      = sat_q;
`endif
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = r_res;
            out_last_d = last1_q;
`ifdef DEQUANT_SAT_EN
            sat_d      = r_sat;
`endif
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Channel counter: restarts after a pixel's last beat, wraps at NUM_CH
   // ---------------------------------------------------------------------------
   always_comb begin
      ch_cnt_d = ch_cnt_q;
      if (in_fire) begin
         if (in_last || (ch_cnt_q == CH_W'(NUM_CH - 1))) begin
            ch_cnt_d = '0;
         end else begin
            ch_cnt_d = ch_cnt_q + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scale table write
   // ---------------------------------------------------------------------------
   always_comb begin
      scale_d = scale_q;
      if (cfg_we && (int'(cfg_addr) < NUM_CH)) begin
         scale_d[cfg_addr] = cfg_scale;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         d1_q       <= '0;
         sc1_q      <= '0;
         last1_q    <= 1'b0;
         s2_valid_q <= 1'b0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         ch_cnt_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            scale_q[i] <= SCALE_W'(1);
         end
      end else begin
         s1_valid_q <= s1_valid_d;
         d1_q       <= d1_d;
         sc1_q      <= sc1_d;
         last1_q    <= last1_d;
         s2_valid_q <= s2_valid_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         ch_cnt_q   <= ch_cnt_d;
         scale_q    <= scale_d;
      end
   end

`ifdef DEQUANT_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= sat_d;
      end
   end
`endif

endmodule
